// File: rtl/fp_result_checker.sv
// ---------------------------------------------------------------------------
// fp_result_checker
//
// Purpose:
//   Response-side checker for the floating-point add/sub datapath. Expected
//   results arrive from the vector loader tagged with their input ID and are
//   queued in a small circular FIFO. Each valid DUT result pops the FIFO head.
//   The checker classifies the pair as pass, zero-sign warning, LSB warning,
//   fail or sequence error, and counts the outcome in saturating counters.
//   The first failure is captured so that a hardware regression run can be
//   debugged without a simulator.
//
// Ports:
//   i_Clk          clock, rising edge
//   i_ARst_n       asynchronous active-low reset
//   i_Clr          synchronous clear of FIFO, counters, sticky flags, capture
//   i_ExpDv        expected-result push strobe
//   iv_ExpResult   expected IEEE754 word
//   i4_ExpID       ID tag of the expected word
//   iv_DutResult   DUT result word
//   i4_DutID       DUT output ID, nonzero marks a valid result
//   i_DutOverflow  DUT overflow flag, aligned with iv_DutResult
//   o_Pass/o_Fail/o_LsbWarn/o_ZeroWarn  one-cycle result pulses
//   o_Full/o_Empty FIFO status
//   o_Overrun      sticky, push attempted while full
//   o_Underrun     sticky, DUT result arrived with FIFO empty
//   ov_PassCnt/ov_FailCnt/ov_WarnCnt    saturating statistics counters
//   o_FirstFailVld sticky, capture registers hold the first failure
//   ov_FailExp/ov_FailDut/o4_FailID     captured first-failure data
// ---------------------------------------------------------------------------
module fp_result_checker #(
  parameter int pWidthExp  = 8,
  parameter int pWidthMan  = 23,
  parameter int pDepthLog2 = 4,
  parameter int pCntW      = 16
) (
  input  logic                                 i_Clk,
  input  logic                                 i_ARst_n,
  input  logic                                 i_Clr,
  input  logic                                 i_ExpDv,
  input  logic [pWidthExp+pWidthMan:0]         iv_ExpResult,
  input  logic [3:0]                           i4_ExpID,
  input  logic [pWidthExp+pWidthMan:0]         iv_DutResult,
  input  logic [3:0]                           i4_DutID,
  input  logic                                 i_DutOverflow,
  output logic                                 o_Pass,
  output logic                                 o_Fail,
  output logic                                 o_LsbWarn,
  output logic                                 o_ZeroWarn,
  output logic                                 o_Full,
  output logic                                 o_Empty,
  output logic                                 o_Overrun,
  output logic                                 o_Underrun,
  output logic [pCntW-1:0]                     ov_PassCnt,
  output logic [pCntW-1:0]                     ov_FailCnt,
  output logic [pCntW-1:0]                     ov_WarnCnt,
  output logic                                 o_FirstFailVld,
  output logic [pWidthExp+pWidthMan:0]         ov_FailExp,
  output logic [pWidthExp+pWidthMan:0]         ov_FailDut,
  output logic [3:0]                           o4_FailID
);

  localparam int pW     = pWidthExp + pWidthMan + 1;
  localparam int cDepth = 1 << pDepthLog2;
  localparam logic [pDepthLog2:0] cDepthCnt = (pDepthLog2+1)'(cDepth);
  localparam logic [pW:0]         cOne      = (pW+1)'(1);

  // FIFO storage: each entry is {ID, result}
  logic [pW+3:0]           r_Mem [cDepth];
  logic [pDepthLog2-1:0]   r_WrPtr;
  logic [pDepthLog2-1:0]   r_RdPtr;
  logic [pDepthLog2:0]     r_Count;

  logic                    r_Pass;
  logic                    r_Fail;
  logic                    r_LsbWarn;
  logic                    r_ZeroWarn;
  logic                    r_Overrun;
  logic                    r_Underrun;
  logic [pCntW-1:0]        r_PassCnt;
  logic [pCntW-1:0]        r_FailCnt;
  logic [pCntW-1:0]        r_WarnCnt;
  logic                    r_FirstFailVld;
  logic [pW-1:0]           r_FailExp;
  logic [pW-1:0]           r_FailDut;
  logic [3:0]              r_FailID;

  logic                    w_Full;
  logic                    w_Empty;
  logic                    w_Check;
  logic                    w_Pop;
  logic                    w_Push;
  logic                    w_Drop;
  logic [pW+3:0]           w_HeadEntry;
  logic [3:0]              w_HeadID;
  logic [pW-1:0]           w_HeadRes;

  logic                    w_ExpSign;
  logic [pWidthExp-1:0]    w_ExpExp;
  logic [pWidthMan-1:0]    w_ExpMan;
  logic                    w_DutSign;
  logic [pWidthExp-1:0]    w_DutExp;
  logic [pWidthMan-1:0]    w_DutMan;
  logic                    w_ExpIsInf;
  logic                    w_ExpIsNaN;
  logic                    w_DutIsInf;
  logic                    w_DutIsNaN;
  logic                    w_BothZero;
  logic [pW:0]             w_DiffFwd;
  logic [pW:0]             w_DiffRev;
  logic                    w_OffByOne;

  logic                    w_ClsPass;
  logic                    w_ClsFail;
  logic                    w_ClsLsb;
  logic                    w_ClsZero;
  logic                    w_ClsUnder;

  assign w_Full      = (r_Count == cDepthCnt);
  assign w_Empty     = (r_Count == '0);
  assign w_Check     = (i4_DutID != 4'd0);
  assign w_HeadEntry = r_Mem[r_RdPtr];
  assign w_HeadID    = w_HeadEntry[pW+3:pW];
  assign w_HeadRes   = w_HeadEntry[pW-1:0];

  // A pop frees a slot on the same edge, so a push into a full FIFO is still
  // accepted when a valid result is popped. There is no empty bypass: a pop
  // against an empty FIFO is an underrun even if a push arrives alongside.
  assign w_Pop  = w_Check & ~w_Empty;
  assign w_Push = i_ExpDv & (~w_Full | w_Pop);
  assign w_Drop = i_ExpDv & w_Full & ~w_Pop;

  assign w_ExpSign = w_HeadRes[pW-1];
  assign w_ExpExp  = w_HeadRes[pW-2:pWidthMan];
  assign w_ExpMan  = w_HeadRes[pWidthMan-1:0];
  assign w_DutSign = iv_DutResult[pW-1];
  assign w_DutExp  = iv_DutResult[pW-2:pWidthMan];
  assign w_DutMan  = iv_DutResult[pWidthMan-1:0];

  assign w_ExpIsInf = (&w_ExpExp) & ~(|w_ExpMan);
  assign w_ExpIsNaN = (&w_ExpExp) &  (|w_ExpMan);
  assign w_DutIsInf = (&w_DutExp) & ~(|w_DutMan);
  assign w_DutIsNaN = (&w_DutExp) &  (|w_DutMan);
  assign w_BothZero = ~(|w_HeadRes[pW-2:0]) & ~(|iv_DutResult[pW-2:0]);

  // One extra bit keeps the subtraction from wrapping, so all-ones vs zero is
  // not mistaken for a one-LSB difference.
  assign w_DiffFwd  = {1'b0, w_HeadRes} - {1'b0, iv_DutResult};
  assign w_DiffRev  = {1'b0, iv_DutResult} - {1'b0, w_HeadRes};
  assign w_OffByOne = (w_DiffFwd == cOne) | (w_DiffRev == cOne);

  // Classification of the FIFO head against the DUT word, in priority order:
  // sequence errors first, then IEEE specials, then exact and tolerance rules.
  always_comb begin
    w_ClsPass  = 1'b0;
    w_ClsFail  = 1'b0;
    w_ClsLsb   = 1'b0;
    w_ClsZero  = 1'b0;
    w_ClsUnder = 1'b0;
    if (w_Check) begin
      if (w_Empty) begin
        w_ClsFail  = 1'b1;
        w_ClsUnder = 1'b1;
      end else if (w_HeadID != i4_DutID) begin
        w_ClsFail = 1'b1;
      end else if (w_ExpIsInf) begin
        if (w_DutIsInf && (w_DutSign == w_ExpSign) && i_DutOverflow)
          w_ClsPass = 1'b1;
        else
          w_ClsFail = 1'b1;
      end else if (w_ExpIsNaN) begin
        if (w_DutIsNaN)
          w_ClsPass = 1'b1;
        else
          w_ClsFail = 1'b1;
      end else if (w_HeadRes == iv_DutResult) begin
        w_ClsPass = 1'b1;
      end else if (w_BothZero) begin
        w_ClsPass = 1'b1;
        w_ClsZero = 1'b1;
      end else if (w_OffByOne) begin
        w_ClsFail = 1'b1;
        w_ClsLsb  = 1'b1;
      end else begin
        w_ClsFail = 1'b1;
      end
    end
  end

  // FIFO data array; not reset since occupancy alone defines valid entries.
  always_ff @(posedge i_Clk) begin
    if (w_Push && !i_Clr)
      r_Mem[r_WrPtr] <= {i4_ExpID, iv_ExpResult};
  end

  // Pointers, occupancy, result pulses, statistics and first-fail capture.
  // Clear behaves like reset but synchronously and overrides all inputs.
  always_ff @(posedge i_Clk or negedge i_ARst_n) begin
    if (!i_ARst_n) begin
      r_WrPtr        <= '0;
      r_RdPtr        <= '0;
      r_Count        <= '0;
      r_Pass         <= 1'b0;
      r_Fail         <= 1'b0;
      r_LsbWarn      <= 1'b0;
      r_ZeroWarn     <= 1'b0;
      r_Overrun      <= 1'b0;
      r_Underrun     <= 1'b0;
      r_PassCnt      <= '0;
      r_FailCnt      <= '0;
      r_WarnCnt      <= '0;
      r_FirstFailVld <= 1'b0;
      r_FailExp      <= '0;
      r_FailDut      <= '0;
      r_FailID       <= '0;
    end else if (i_Clr) begin
      r_WrPtr        <= '0;
      r_RdPtr        <= '0;
      r_Count        <= '0;
      r_Pass         <= 1'b0;
      r_Fail         <= 1'b0;
      r_LsbWarn      <= 1'b0;
      r_ZeroWarn     <= 1'b0;
      r_Overrun      <= 1'b0;
      r_Underrun     <= 1'b0;
      r_PassCnt      <= '0;
      r_FailCnt      <= '0;
      r_WarnCnt      <= '0;
      r_FirstFailVld <= 1'b0;
      r_FailExp      <= '0;
      r_FailDut      <= '0;
      r_FailID       <= '0;
    end else begin
      if (w_Push)
        r_WrPtr <= r_WrPtr + 1'b1;
      if (w_Pop)
        r_RdPtr <= r_RdPtr + 1'b1;
      if (w_Push && !w_Pop)
        r_Count <= r_Count + 1'b1;
      else if (!w_Push && w_Pop)
        r_Count <= r_Count - 1'b1;

      r_Overrun  <= r_Overrun  | w_Drop;
      r_Underrun <= r_Underrun | w_ClsUnder;

      r_Pass     <= w_ClsPass;
      r_Fail     <= w_ClsFail;
      r_LsbWarn  <= w_ClsLsb;
      r_ZeroWarn <= w_ClsZero;

      if (w_ClsPass && !(&r_PassCnt))
        r_PassCnt <= r_PassCnt + 1'b1;
      if (w_ClsFail && !(&r_FailCnt))
        r_FailCnt <= r_FailCnt + 1'b1;
      if ((w_ClsLsb || w_ClsZero) && !(&r_WarnCnt))
        r_WarnCnt <= r_WarnCnt + 1'b1;

      if (w_ClsFail && !r_FirstFailVld) begin
        r_FirstFailVld <= 1'b1;
        r_FailExp      <= w_ClsUnder ? '0 : w_HeadRes;
        r_FailDut      <= iv_DutResult;
        r_FailID       <= i4_DutID;
      end
    end
  end

  assign o_Pass         = r_Pass;
  assign o_Fail         = r_Fail;
  assign o_LsbWarn      = r_LsbWarn;
  assign o_ZeroWarn     = r_ZeroWarn;
  assign o_Full         = w_Full;
  assign o_Empty        = w_Empty;
  assign o_Overrun      = r_Overrun;
  assign o_Underrun     = r_Underrun;
  assign ov_PassCnt     = r_PassCnt;
  assign ov_FailCnt     = r_FailCnt;
  assign ov_WarnCnt     = r_WarnCnt;
  assign o_FirstFailVld = r_FirstFailVld;
  assign ov_FailExp     = r_FailExp;
  assign ov_FailDut     = r_FailDut;
  assign o4_FailID      = r_FailID;

endmodule

// File: tb/tb_fp_result_checker.sv
// ---------------------------------------------------------------------------
// tb_fp_result_checker
//
// Purpose:
//   Directed bench for fp_result_checker with 4-bit counters so saturation is
//   reachable. A queue-based model predicts every output from the stream of
//   pushes and DUT results; a compare process checks the DUT against it each
//   cycle, and literal expectations pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_fp_result_checker;

  localparam int cCntW  = 4;
  localparam int cDepth = 16;
  localparam int cCntMax = (1 << cCntW) - 1;

  logic        i_Clk = 1'b0;
  logic        i_ARst_n;
  logic        i_Clr;
  logic        i_ExpDv;
  logic [31:0] iv_ExpResult;
  logic [3:0]  i4_ExpID;
  logic [31:0] iv_DutResult;
  logic [3:0]  i4_DutID;
  logic        i_DutOverflow;
  logic        o_Pass, o_Fail, o_LsbWarn, o_ZeroWarn;
  logic        o_Full, o_Empty, o_Overrun, o_Underrun;
  logic [cCntW-1:0] ov_PassCnt, ov_FailCnt, ov_WarnCnt;
  logic        o_FirstFailVld;
  logic [31:0] ov_FailExp, ov_FailDut;
  logic [3:0]  o4_FailID;

  int checks   = 0;
  int failures = 0;
  bit cmpEn    = 1'b0;

  always #5 i_Clk = ~i_Clk;

  fp_result_checker #(
    .pWidthExp (8),
    .pWidthMan (23),
    .pDepthLog2(4),
    .pCntW     (cCntW)
  ) dut (
    .i_Clk         (i_Clk),
    .i_ARst_n      (i_ARst_n),
    .i_Clr         (i_Clr),
    .i_ExpDv       (i_ExpDv),
    .iv_ExpResult  (iv_ExpResult),
    .i4_ExpID      (i4_ExpID),
    .iv_DutResult  (iv_DutResult),
    .i4_DutID      (i4_DutID),
    .i_DutOverflow (i_DutOverflow),
    .o_Pass        (o_Pass),
    .o_Fail        (o_Fail),
    .o_LsbWarn     (o_LsbWarn),
    .o_ZeroWarn    (o_ZeroWarn),
    .o_Full        (o_Full),
    .o_Empty       (o_Empty),
    .o_Overrun     (o_Overrun),
    .o_Underrun    (o_Underrun),
    .ov_PassCnt    (ov_PassCnt),
    .ov_FailCnt    (ov_FailCnt),
    .ov_WarnCnt    (ov_WarnCnt),
    .o_FirstFailVld(o_FirstFailVld),
    .ov_FailExp    (ov_FailExp),
    .ov_FailDut    (ov_FailDut),
    .o4_FailID     (o4_FailID)
  );

  // Model state
  logic [35:0] mQ[$];
  bit          mPass, mFail, mLsb, mZero, mOver, mUnder, mFfVld;
  int          mPassCnt, mFailCnt, mWarnCnt;
  logic [31:0] mFailExp, mFailDut;
  logic [3:0]  mFailId;

  typedef enum int {kPass, kZero, kLsb, kFail} verdict_e;

  // Judge one expected/DUT pair from the IEEE field rules.
  function automatic verdict_e judge(logic [31:0] e, logic [3:0] eId,
                                     logic [31:0] d, logic [3:0] dId, bit ov);
    logic [7:0]  eExp, dExp;
    logic [22:0] eMan, dMan;
    longint      diff;
    eExp = e[30:23]; eMan = e[22:0];
    dExp = d[30:23]; dMan = d[22:0];
    if (eId != dId) return kFail;
    if (eExp == 8'hFF && eMan == 0) return (d == e && ov) ? kPass : kFail;
    if (eExp == 8'hFF) return (dExp == 8'hFF && dMan != 0) ? kPass : kFail;
    if (e == d) return kPass;
    if (e[30:0] == 0 && d[30:0] == 0) return kZero;
    diff = longint'(e) - longint'(d);
    if (diff == 1 || diff == -1) return kLsb;
    return kFail;
  endfunction

  function automatic int sat(int v);
    return (v > cCntMax) ? cCntMax : v;
  endfunction

  task automatic modelClear();
    mQ.delete();
    mPass = 0; mFail = 0; mLsb = 0; mZero = 0;
    mOver = 0; mUnder = 0; mFfVld = 0;
    mPassCnt = 0; mFailCnt = 0; mWarnCnt = 0;
    mFailExp = 0; mFailDut = 0; mFailId = 0;
  endtask

  task automatic modelStep();
    int          n;
    bit          popped;
    logic [35:0] head;
    verdict_e    v;
    n = mQ.size();
    popped = 0;
    head = '0;
    mPass = 0; mFail = 0; mLsb = 0; mZero = 0;
    if (i4_DutID != 0) begin
      if (n == 0) begin
        mFail = 1; mUnder = 1;
      end else begin
        head = mQ.pop_front();
        popped = 1;
        v = judge(head[31:0], head[35:32], iv_DutResult, i4_DutID, i_DutOverflow);
        mPass = (v == kPass) || (v == kZero);
        mZero = (v == kZero);
        mLsb  = (v == kLsb);
        mFail = (v == kLsb) || (v == kFail);
      end
    end
    if (i_ExpDv) begin
      if (n < cDepth || popped) mQ.push_back({i4_ExpID, iv_ExpResult});
      else mOver = 1;
    end
    if (mPass) mPassCnt = sat(mPassCnt + 1);
    if (mFail) mFailCnt = sat(mFailCnt + 1);
    if (mLsb || mZero) mWarnCnt = sat(mWarnCnt + 1);
    if (mFail && !mFfVld) begin
      mFfVld   = 1;
      mFailExp = popped ? head[31:0] : 32'h0;
      mFailDut = iv_DutResult;
      mFailId  = i4_DutID;
    end
  endtask

  // Model advances on the same edges as the DUT registers.
  always @(posedge i_Clk or negedge i_ARst_n) begin
    if (!i_ARst_n) modelClear();
    else if (i_Clr) modelClear();
    else modelStep();
  end

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Compare every output against the model once per cycle, away from the edge.
  always @(negedge i_Clk) begin
    if (cmpEn) begin
      checkOutput("m.pass",     32'(o_Pass),         32'(mPass));
      checkOutput("m.fail",     32'(o_Fail),         32'(mFail));
      checkOutput("m.lsbwarn",  32'(o_LsbWarn),      32'(mLsb));
      checkOutput("m.zerowarn", 32'(o_ZeroWarn),     32'(mZero));
      checkOutput("m.full",     32'(o_Full),         32'(mQ.size() == cDepth));
      checkOutput("m.empty",    32'(o_Empty),        32'(mQ.size() == 0));
      checkOutput("m.overrun",  32'(o_Overrun),      32'(mOver));
      checkOutput("m.underrun", 32'(o_Underrun),     32'(mUnder));
      checkOutput("m.passcnt",  32'(ov_PassCnt),     32'(mPassCnt));
      checkOutput("m.failcnt",  32'(ov_FailCnt),     32'(mFailCnt));
      checkOutput("m.warncnt",  32'(ov_WarnCnt),     32'(mWarnCnt));
      checkOutput("m.ffvld",    32'(o_FirstFailVld), 32'(mFfVld));
      checkOutput("m.failexp",  ov_FailExp,          mFailExp);
      checkOutput("m.faildut",  ov_FailDut,          mFailDut);
      checkOutput("m.failid",   32'(o4_FailID),      32'(mFailId));
    end
  end

  task automatic applyStimulus(bit clr, bit ed, logic [31:0] er, logic [3:0] ei,
                               logic [31:0] dr, logic [3:0] di, bit ov);
    @(negedge i_Clk);
    i_Clr = clr; i_ExpDv = ed; iv_ExpResult = er; i4_ExpID = ei;
    iv_DutResult = dr; i4_DutID = di; i_DutOverflow = ov;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 32'h0, 4'd0, 32'h0, 4'd0, 0);
  endtask

  task automatic push(logic [31:0] er, logic [3:0] ei);
    applyStimulus(0, 1, er, ei, 32'h0, 4'd0, 0);
  endtask

  task automatic result(logic [31:0] dr, logic [3:0] di, bit ov);
    applyStimulus(0, 0, 32'h0, 4'd0, dr, di, ov);
  endtask

  task automatic clear();
    applyStimulus(1, 0, 32'h0, 4'd0, 32'h0, 4'd0, 0);
  endtask

  initial begin
    i_ARst_n = 1'b0;
    i_Clr = 0; i_ExpDv = 0; iv_ExpResult = 0; i4_ExpID = 0;
    iv_DutResult = 0; i4_DutID = 0; i_DutOverflow = 0;
    #12;
    checkOutput("rst.empty",   32'(o_Empty), 32'd1);
    checkOutput("rst.passcnt", 32'(ov_PassCnt), 32'd0);
    checkOutput("rst.ffvld",   32'(o_FirstFailVld), 32'd0);
    @(negedge i_Clk); #2 i_ARst_n = 1'b1;
    cmpEn = 1'b1;

    $display("[TB] exact stream");
    for (int c = 0; c < 10; c++) begin
      applyStimulus(0, c < 7, 32'h3F800000, 4'(c + 1),
                    32'h3F800000, (c >= 3) ? 4'(c - 2) : 4'd0, 0);
    end
    idle();
    checkOutput("exact.passcnt", 32'(ov_PassCnt), 32'd7);
    checkOutput("exact.failcnt", 32'(ov_FailCnt), 32'd0);
    checkOutput("exact.empty",   32'(o_Empty), 32'd1);

    $display("[TB] async reset mid-stream");
    push(32'h3F800000, 4'd1);
    push(32'h3F800000, 4'd2);
    push(32'h3F800000, 4'd3);
    idle();
    checkOutput("pre.empty", 32'(o_Empty), 32'd0);
    #2 i_ARst_n = 1'b0;
    #1;
    checkOutput("arst.empty",   32'(o_Empty), 32'd1);
    checkOutput("arst.passcnt", 32'(ov_PassCnt), 32'd0);
    @(negedge i_Clk); #2 i_ARst_n = 1'b1;
    result(32'h3F800000, 4'd1, 0);
    idle();
    checkOutput("arst.underrun", 32'(o_Underrun), 32'd1);
    checkOutput("arst.fail",     32'(o_Fail), 32'd1);
    checkOutput("arst.failexp",  ov_FailExp, 32'h0);

    $display("[TB] lsb warning");
    clear();
    push(32'h40000000, 4'd1);
    result(32'h40000001, 4'd1, 0);
    idle();
    checkOutput("lsb.fail",    32'(o_Fail), 32'd1);
    checkOutput("lsb.warn",    32'(o_LsbWarn), 32'd1);
    checkOutput("lsb.failexp", ov_FailExp, 32'h40000000);
    checkOutput("lsb.faildut", ov_FailDut, 32'h40000001);
    checkOutput("lsb.failid",  32'(o4_FailID), 32'd1);

    $display("[TB] zero sign warning");
    clear();
    push(32'h00000000, 4'd2);
    result(32'h80000000, 4'd2, 0);
    idle();
    checkOutput("zero.pass",    32'(o_Pass), 32'd1);
    checkOutput("zero.warn",    32'(o_ZeroWarn), 32'd1);
    checkOutput("zero.warncnt", 32'(ov_WarnCnt), 32'd1);

    $display("[TB] specials");
    push(32'h7F800000, 4'd3);
    result(32'h7F800000, 4'd3, 1);
    idle();
    checkOutput("inf.ovf1", 32'(o_Pass), 32'd1);
    push(32'h7F800000, 4'd3);
    result(32'h7F800000, 4'd3, 0);
    idle();
    checkOutput("inf.ovf0", 32'(o_Fail), 32'd1);
    push(32'h7F800000, 4'd3);
    result(32'hFF800000, 4'd3, 1);
    push(32'h7FC00000, 4'd4);
    result(32'hFF800001, 4'd4, 0);
    idle();
    checkOutput("nan.pass", 32'(o_Pass), 32'd1);
    push(32'h3F800001, 4'd5);
    result(32'h3F800000, 4'd5, 0);
    push(32'h00000000, 4'd6);
    result(32'hFFFFFFFF, 4'd6, 0);
    idle();
    checkOutput("wrap.nolsb", 32'(o_LsbWarn), 32'd0);

    $display("[TB] id mismatch");
    push(32'h3F800000, 4'd2);
    result(32'h3F800000, 4'd3, 0);
    idle();
    checkOutput("id.fail", 32'(o_Fail), 32'd1);

    $display("[TB] full and overrun");
    clear();
    for (int i = 0; i < 17; i++) push(32'(i), 4'((i % 7) + 1));
    idle();
    checkOutput("full.full",    32'(o_Full), 32'd1);
    checkOutput("full.overrun", 32'(o_Overrun), 32'd1);
    applyStimulus(0, 1, 32'd100, 4'd6, 32'd0, 4'd1, 0);
    idle();
    checkOutput("full.pushpop", 32'(o_Full), 32'd1);
    checkOutput("full.pass",    32'(o_Pass), 32'd1);
    for (int i = 1; i < 16; i++) result(32'(i), 4'((i % 7) + 1), 0);
    result(32'd100, 4'd6, 0);
    idle();
    checkOutput("drain.empty", 32'(o_Empty), 32'd1);
    checkOutput("drain.pass",  32'(o_Pass), 32'd1);

    $display("[TB] push and pop while empty");
    clear();
    applyStimulus(0, 1, 32'h00001234, 4'd5, 32'h00001234, 4'd5, 0);
    idle();
    checkOutput("epp.underrun", 32'(o_Underrun), 32'd1);
    checkOutput("epp.retained", 32'(o_Empty), 32'd0);
    result(32'h00001234, 4'd5, 0);
    idle();
    checkOutput("epp.pass", 32'(o_Pass), 32'd1);

    $display("[TB] saturation and clear");
    clear();
    for (int c = 0; c < 21; c++) begin
      applyStimulus(0, c < 20, 32'h3F800000 + 32'(c), 4'((c % 7) + 1),
                    32'h3F800000 + 32'(c - 1),
                    (c >= 1) ? 4'(((c - 1) % 7) + 1) : 4'd0, 0);
    end
    idle();
    checkOutput("sat.passcnt", 32'(ov_PassCnt), 32'd15);
    checkOutput("sat.failcnt", 32'(ov_FailCnt), 32'd0);
    result(32'h1, 4'd1, 0);
    idle();
    checkOutput("sat.underrun", 32'(o_Underrun), 32'd1);
    clear();
    idle();
    checkOutput("clr.passcnt",  32'(ov_PassCnt), 32'd0);
    checkOutput("clr.failcnt",  32'(ov_FailCnt), 32'd0);
    checkOutput("clr.underrun", 32'(o_Underrun), 32'd0);
    checkOutput("clr.ffvld",    32'(o_FirstFailVld), 32'd0);
    idle();

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_result_checker.md
Name: fp_result_checker

Overview:
- Synthesizable response-side checker for the floating-point add/sub datapath; the receiving end of the float vector loader stream.
- The loader side pushes expected results, each tagged with its input ID, into an internal FIFO.
- The DUT side presents results tagged with the output ID. Each valid DUT result pops the FIFO head, is classified (pass, LSB warning, zero-sign warning, fail, sequence error), and is counted.
- The first failure is captured for on-chip debug, so hardware regression runs need no simulator.

Parameters:
pWidthExp, 8, exponent width
pWidthMan, 23, mantissa width (word width pW = pWidthExp+pWidthMan+1)
pDepthLog2, 4, expected-result FIFO depth = 2**pDepthLog2
pCntW, 16, width of statistics counters

Ports:
i_Clk  in  1  clock, all logic on rising edge
i_ARst_n  in  1  asynchronous active-low reset
i_Clr  in  1  synchronous clear of FIFO, counters, sticky flags and capture registers
i_ExpDv  in  1  expected-result push strobe
iv_ExpResult  in  pW  expected IEEE754 result
i4_ExpID  in  4  ID tag of expected result (1..7)
iv_DutResult  in  pW  DUT result
i4_DutID  in  4  DUT output ID; nonzero = valid result this cycle
i_DutOverflow  in  1  DUT overflow flag, aligned with iv_DutResult
o_Pass  out  1  one-cycle pulse: result passed
o_Fail  out  1  one-cycle pulse: result failed (mismatch, ID error or underrun)
o_LsbWarn  out  1  one-cycle pulse: results differ by exactly 1 (as integers)
o_ZeroWarn  out  1  one-cycle pulse: both results zero, signs differ
o_Full  out  1  FIFO full
o_Empty  out  1  FIFO empty
o_Overrun  out  1  sticky: push attempted while full
o_Underrun  out  1  sticky: DUT result arrived with FIFO empty
ov_PassCnt/ov_FailCnt/ov_WarnCnt  out  pCntW each  saturating counters
o_FirstFailVld  out  1  sticky: capture registers hold the first failure
ov_FailExp/ov_FailDut  out  pW each  captured expected and DUT words
o4_FailID  out  4  captured DUT ID

Behaviour:
- Reset (i_ARst_n=0, asynchronous): every output is 0 except o_Empty=1. FIFO pointers are cleared. i_Clr has the same effect, applied synchronously, and takes priority over all other inputs that cycle.
- FIFO: circular buffer of {ID,result}, with a pDepthLog2+1-bit occupancy count.
  - A push while full is dropped and sets o_Overrun.
  - Simultaneous push and pop when full: both are accepted and occupancy is unchanged.
  - Simultaneous push and pop when empty: the push is stored; the pop is an underrun (no bypass).
  - Pointers wrap modulo depth.
- Check event: i4_DutID != 0. The FIFO head is compared combinationally; result pulses and counters update on the next rising edge (latency 1). The head is popped on the same edge.
- Classification, in priority order:
  1. FIFO empty: Fail, set o_Underrun.
  2. Head ID != i4_DutID: Fail.
  3. Expected Inf (exp all ones, mantissa 0): Pass if the DUT is Inf with the same sign and i_DutOverflow=1; else Fail.
  4. Expected NaN (exp all ones, mantissa != 0): Pass if the DUT exp is all ones and its mantissa is != 0, sign ignored; else Fail.
  5. Exact bit match: Pass.
  6. Both low pW-1 bits zero: ZeroWarn, counted in WarnCnt and also as Pass (o_Pass=1).
  7. |Exp - Dut| = 1 as unsigned pW-bit integers: LsbWarn + Fail.
  8. Otherwise: Fail.
- Pulse exclusivity: at most one of o_Pass and o_Fail per cycle. o_LsbWarn only accompanies o_Fail; o_ZeroWarn only accompanies o_Pass.
- Counters: saturate at all ones and never wrap.
- First-fail capture: loaded on the first Fail while o_FirstFailVld=0. On underrun, ov_FailExp=0. The capture holds until reset or i_Clr.

Test Plan:
- Reset: push 3 entries, then pull i_ARst_n low mid-stream -> o_Empty=1, all counters 0, next DUT result gives o_Underrun=1 and o_Fail pulse.
- Exact stream: push 0x3F800000 with IDs 1..7 and return the identical DUT stream 3 cycles later -> 7 o_Pass pulses, ov_PassCnt=7, ov_FailCnt=0, o_Empty=1.
- Tolerance classes:
  - Exp 0x40000000, DUT 0x40000001 -> o_Fail and o_LsbWarn; capture holds both words and the ID.
  - Exp 0x00000000, DUT 0x80000000 -> o_Pass and o_ZeroWarn, ov_WarnCnt=1.
- Specials:
  - Exp 0x7F800000, DUT 0x7F800000 with overflow=1 -> Pass; same with overflow=0 -> Fail.
  - Exp 0x7FC00000, DUT 0xFF800001 -> Pass.
- Boundaries:
  - Push 17 with depth 16 -> o_Full=1 and o_Overrun=1.
  - Push and pop together while full -> count stays 16.
  - Push and pop together while empty -> Underrun, entry retained.
  - DUT ID 3 against head ID 2 -> Fail.
- Saturation and clear: pCntW=4, 20 passes -> ov_PassCnt=15; then i_Clr -> all counters and sticky flags 0 the next cycle.
